// File: rtl/fft_pkg.sv
// Shared FFT types, N=4 twiddle constants and wide fixed-point helpers
// used by the butterfly datapath.
package fft_pkg;
  localparam int HALF_DEF = 16;
  localparam int ACC_W    = 72;

  typedef logic signed [ACC_W-1:0] acc_t;

  typedef struct packed {
    logic signed [HALF_DEF-1:0] re;
    logic signed [HALF_DEF-1:0] im;
  } cplx_t;

  localparam cplx_t W0 = '{re: 16'sh7fff, im: 16'sh0000};
  localparam cplx_t W1 = '{re: 16'sh0000, im: 16'sh8001};
  localparam cplx_t W2 = '{re: 16'sh8000, im: 16'sh0000};
  localparam cplx_t W3 = '{re: 16'sh0000, im: 16'sh7fff};

  // Round half up, then arithmetic shift right by sh (sh >= 1).
  function automatic acc_t round_shift(input acc_t x, input int sh);
    acc_t half_lsb;
    half_lsb = acc_t'(1) <<< (sh - 1);
    return (x + half_lsb) >>> sh;
  endfunction

  // Clip to a signed range of the given width, flagging when clipping occurred.
  function automatic acc_t sat_clip(input acc_t x, input int bits, output logic sat);
    acc_t hi;
    acc_t lo;
    hi  = (acc_t'(1) <<< (bits - 1)) - acc_t'(1);
    lo  = -(acc_t'(1) <<< (bits - 1));
    sat = 1'b1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    sat = 1'b0;
    return x;
  endfunction
endpackage

// File: rtl/cmul_round.sv
// Pipelined complex multiply B*W with rounding back to Q(HALF-1) scale;
// one register stage, held when i_en is low.
module cmul_round
  import fft_pkg::*;
#(
  parameter int HALF = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_en,
  input  logic [2*HALF-1:0]      i_b,
  input  logic [2*HALF-1:0]      i_w,
  output logic signed [HALF+1:0] o_p_re,
  output logic signed [HALF+1:0] o_p_im
);
  logic signed [HALF-1:0]   w_br, w_bi, w_wr, w_wi;
  logic signed [2*HALF-1:0] w_m_rr, w_m_ii, w_m_ri, w_m_ir;
  logic signed [2*HALF:0]   w_pr, w_pi;
  logic signed [HALF+1:0]   w_pr_rnd, w_pi_rnd;
  logic signed [HALF+1:0]   r_p_re, r_p_im;

  assign w_br = i_b[2*HALF-1:HALF];
  assign w_bi = i_b[HALF-1:0];
  assign w_wr = i_w[2*HALF-1:HALF];
  assign w_wi = i_w[HALF-1:0];

  assign w_m_rr = (2*HALF)'(w_br) * (2*HALF)'(w_wr);
  assign w_m_ii = (2*HALF)'(w_bi) * (2*HALF)'(w_wi);
  assign w_m_ri = (2*HALF)'(w_br) * (2*HALF)'(w_wi);
  assign w_m_ir = (2*HALF)'(w_bi) * (2*HALF)'(w_wr);

  // One guard bit so that (-2^(HALF-1))^2 + (-2^(HALF-1))^2 cannot wrap.
  assign w_pr = (2*HALF+1)'(w_m_rr) - (2*HALF+1)'(w_m_ii);
  assign w_pi = (2*HALF+1)'(w_m_ri) + (2*HALF+1)'(w_m_ir);

  assign w_pr_rnd = (HALF+2)'(round_shift(ACC_W'(w_pr), HALF - 1));
  assign w_pi_rnd = (HALF+2)'(round_shift(ACC_W'(w_pi), HALF - 1));

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its predecessor's pre-edge value, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_re <= '0;
      r_p_im <= '0;
    end else if (i_en) begin
      r_p_re <= w_pr_rnd;
      r_p_im <= w_pi_rnd;
    end
  end

  assign o_p_re = r_p_re;
  assign o_p_im = r_p_im;
endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly with valid/ready handshake, global stall,
// optional divide-by-2 stage scaling and per-component saturation.
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] w,
  input  logic             scale,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             sat
);
  localparam int HALF = WIDTH / 2;

  logic             w_en;
  logic [WIDTH-1:0] r_a1, r_b1, r_w1, r_a2;
  logic             r_s1, r_s2, r_v1, r_v2, r_v3;
  logic [WIDTH-1:0] r_out0, r_out1;
  logic             r_sat;

  logic signed [HALF+1:0] w_p_re, w_p_im;
  logic signed [HALF-1:0] w_a_re, w_a_im;
  logic signed [HALF+2:0] w_sum [4];
  logic [HALF-1:0]        w_res [4];
  logic [3:0]             w_satv;

  // Single global stall: the whole pipe advances only if S3 can drain.
  assign w_en     = !r_v3 || out_ready;
  assign in_ready = w_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a1 <= '0;
      r_b1 <= '0;
      r_w1 <= '0;
      r_s1 <= 1'b0;
      r_v1 <= 1'b0;
      r_a2 <= '0;
      r_s2 <= 1'b0;
      r_v2 <= 1'b0;
    end else if (w_en) begin
      r_a1 <= a;
      r_b1 <= b;
      r_w1 <= w;
      r_s1 <= scale;
      r_v1 <= in_valid;
      r_a2 <= r_a1;
      r_s2 <= r_s1;
      r_v2 <= r_v1;
    end
  end

  cmul_round #(.HALF(HALF)) u_cmul (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_en),
    .i_b    (r_b1),
    .i_w    (r_w1),
    .o_p_re (w_p_re),
    .o_p_im (w_p_im)
  );

  assign w_a_re = r_a2[WIDTH-1:HALF];
  assign w_a_im = r_a2[HALF-1:0];

  always_comb begin
    w_sum[0] = (HALF+3)'(w_a_re) + (HALF+3)'(w_p_re);
    w_sum[1] = (HALF+3)'(w_a_im) + (HALF+3)'(w_p_im);
    w_sum[2] = (HALF+3)'(w_a_re) - (HALF+3)'(w_p_re);
    w_sum[3] = (HALF+3)'(w_a_im) - (HALF+3)'(w_p_im);
    w_satv   = '0;
    for (int i = 0; i < 4; i++) begin
      acc_t v;
      v = ACC_W'(w_sum[i]);
      if (r_s2) v = round_shift(v, 1);
      v = sat_clip(v, HALF, w_satv[i]);
      w_res[i] = HALF'(v);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out0 <= '0;
      r_out1 <= '0;
      r_sat  <= 1'b0;
      r_v3   <= 1'b0;
    end else if (w_en) begin
      r_out0 <= {w_res[0], w_res[1]};
      r_out1 <= {w_res[2], w_res[3]};
      r_sat  <= |w_satv;
      r_v3   <= r_v2;
    end
  end

  assign out0      = r_out0;
  assign out1      = r_out1;
  assign sat       = r_sat;
  assign out_valid = r_v3;
endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed self-checking bench for butterfly_pipe: latency, twiddles,
// scaling, saturation, backpressure and mid-flight reset.
module tb_butterfly_pipe;
  import fft_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, scale, out_valid, out_ready, sat;
  logic [31:0] a, b, w, out0, out1;
  int          n_tests = 0;
  int          n_fail  = 0;

  butterfly_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .w         (w),
    .scale     (scale),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0      (out0),
    .out1      (out1),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cx(input int re, input int im);
    return {re[15:0], im[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] o0, input logic [31:0] o1,
                            input logic s);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".out0"}, out0, o0);
    check({tag, ".out1"}, out1, o1);
    check({tag, ".sat"}, 32'(sat), 32'(s));
  endtask

  task automatic drive(input logic v, input logic [31:0] ta, input logic [31:0] tb_,
                       input logic [31:0] tw, input logic ts);
    in_valid = v;
    a        = ta;
    b        = tb_;
    w        = tw;
    scale    = ts;
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0);
    tick();
    tick();
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out0", out0, 32'd0);
    check("rst.out1", out1, 32'd0);
    check("rst.sat", 32'(sat), 32'd0);
    rst = 1'b0;
    tick();

    // Latency: accept cycle 0, result visible from cycle 3.
    drive(1'b1, cx(10, 5), cx(20, 15), W0, 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    check("lat.c1", 32'(out_valid), 32'd0);
    tick();
    check("lat.c2", 32'(out_valid), 32'd0);
    tick();
    expect_out("w0", cx(30, 20), cx(-10, -10), 1'b0);
    tick();
    check("w0.drain", 32'(out_valid), 32'd0);

    // Back-to-back W1, W2 (exact -1), W3.
    drive(1'b1, cx(10, 5), cx(20, 15), W1, 1'b0);
    tick();
    drive(1'b1, cx(10, 5), cx(20, 15), W2, 1'b0);
    tick();
    drive(1'b1, cx(10, 5), cx(20, 15), W3, 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    expect_out("w1", cx(25, -15), cx(-5, 25), 1'b0);
    tick();
    expect_out("w2", cx(-10, -10), cx(30, 20), 1'b0);
    tick();
    expect_out("w3", cx(-5, 25), cx(25, -15), 1'b0);
    tick();
    check("w3.drain", 32'(out_valid), 32'd0);

    // Scaling and saturation, back-to-back.
    drive(1'b1, cx(10, 5), cx(20, 15), W0, 1'b1);
    tick();
    drive(1'b1, cx(32767, 0), cx(32767, 0), W0, 1'b0);
    tick();
    drive(1'b1, cx(32767, 0), cx(32767, 0), W0, 1'b1);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    expect_out("scale", cx(15, 10), cx(-5, -5), 1'b0);
    tick();
    expect_out("sat", cx(32767, 0), cx(1, 0), 1'b1);
    tick();
    expect_out("sat.scaled", cx(32767, 0), cx(1, 0), 1'b0);
    tick();

    // Backpressure: T0..T2 enter, then out_ready low for 5 cycles with T3 waiting.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, cx(100 * (k + 1), 7), cx(k + 1, 0), W0, 1'b0);
      tick();
    end
    drive(1'b1, cx(400, 7), cx(4, 0), W0, 1'b0);
    out_ready = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      check("bp.in_ready", 32'(in_ready), 32'd0);
      expect_out("bp.hold", cx(101, 7), cx(99, 7), 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp.release", 32'(in_ready), 32'd1);
    expect_out("bp.t0", cx(101, 7), cx(99, 7), 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    expect_out("bp.t1", cx(202, 7), cx(198, 7), 1'b0);
    tick();
    expect_out("bp.t2", cx(303, 7), cx(297, 7), 1'b0);
    tick();
    expect_out("bp.t3", cx(404, 7), cx(396, 7), 1'b0);
    tick();
    check("bp.drain", 32'(out_valid), 32'd0);

    // Reset with two transactions in flight.
    drive(1'b1, cx(1000, 1), cx(3, 3), W0, 1'b0);
    tick();
    drive(1'b1, cx(2000, 2), cx(4, 4), W0, 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst.out_valid", 32'(out_valid), 32'd0);
    check("mrst.in_ready", 32'(in_ready), 32'd1);
    check("mrst.out0", out0, 32'd0);
    check("mrst.out1", out1, 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("mrst.no_ghost", 32'(out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
